// File: rtl/fpu_pkg.sv
// Shared FP16 definitions for the FPU add/subtract sequencer.
// Contents: sequencer state encoding, FP16 field layout and special constants.
package fpu_pkg;

  localparam int unsigned FP16_EXP_W    = 5;
  localparam int unsigned FP16_FRAC_W   = 10;
  localparam int unsigned FP16_SIGN_POS = FP16_EXP_W + FP16_FRAC_W;

  localparam logic [15:0]           FP16_QNAN    = 16'h7E00;
  localparam logic [FP16_EXP_W-1:0] FP16_EXP_MAX = 5'h1F;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_PACK  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic                   sign;
    logic [FP16_EXP_W-1:0]  exp;
    logic [FP16_FRAC_W-1:0] frac;
  } fp16_t;

endpackage

// File: rtl/fpu_class_detect.sv
// Combinational FP16 operand classifier.
// Ports:
//   op_i        FP16 operand
//   is_zero_c   exponent field is 0 (denormals count as zero)
//   is_inf_c    exponent all ones, fraction zero
//   is_nan_c    exponent all ones, fraction non-zero
module fpu_class_detect
  import fpu_pkg::*;
(
  input  fp16_t op_i,
  output logic  is_zero_c,
  output logic  is_inf_c,
  output logic  is_nan_c
);

  logic exp_max;

  assign exp_max   = (op_i.exp == FP16_EXP_MAX);
  assign is_zero_c = (op_i.exp == '0);
  assign is_inf_c  = exp_max && (op_i.frac == '0);
  assign is_nan_c  = exp_max && (op_i.frac != '0);

endmodule

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle FP16 add/subtract sequencer.
// Walks one operand pair through ALIGN, ADD, NORM and PACK with a single
// mantissa adder and a 1-bit normalize shifter, then holds the result in DONE.
// Build option: FPU_ROUND_EN keeps guard/round/sticky bits and rounds to
// nearest-even in PACK; without it shifted-out bits are truncated.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      operand handshake (op_a, op_b, op_sub)
//   out_valid/out_ready    result handshake (result, overflow)
//   busy                   sequencer not idle
module fpu_addsub_seq
  import fpu_pkg::*;
#(
  parameter int unsigned MAN_W    = 11,
  parameter int unsigned EXP_W    = 5,
  parameter int unsigned NORM_MAX = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic        op_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        overflow,
  output logic        busy
);

`ifdef FPU_ROUND_EN
  localparam int unsigned GRS_W = 3;
`else
  localparam int unsigned GRS_W = 0;
`endif
  localparam int unsigned MW  = MAN_W + GRS_W;  // working mantissa width
  localparam int unsigned SW  = MW + 1;         // sum width incl. carry
  localparam int unsigned HID = MW - 1;         // hidden-bit position
  localparam int unsigned XW  = EXP_W + 1;      // exponent with overflow headroom
  localparam int unsigned CW  = $clog2(NORM_MAX + 1);

  state_e         state_q, state_d;
  fp16_t          a_q, a_d, b_q, b_d;
  logic           special_q, special_d;
  logic [15:0]    spec_res_q, spec_res_d;
  logic [MW-1:0]  man_x_q, man_x_d, man_y_q, man_y_d;
  logic           sign_x_q, sign_x_d, sign_y_q, sign_y_d;
  logic [XW-1:0]  exp_q, exp_d;
  logic [SW-1:0]  sum_q, sum_d;
  logic           sign_q, sign_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           out_valid_q, out_valid_d;
  logic [15:0]    result_q, result_d;
  logic           overflow_q, overflow_d;
  logic           in_ready_q, in_ready_d;
  logic           busy_q, busy_d;

  logic zero_a, inf_a, nan_a, zero_b, inf_b, nan_b;

  fpu_class_detect u_class_a (.op_i(a_q), .is_zero_c(zero_a), .is_inf_c(inf_a), .is_nan_c(nan_a));
  fpu_class_detect u_class_b (.op_i(b_q), .is_zero_c(zero_b), .is_inf_c(inf_b), .is_nan_c(nan_b));

  // Alignment datapath: pick the larger exponent, shift the other mantissa right.
  logic             a_big;
  logic [EXP_W-1:0] diff;
  logic [MW-1:0]    man_a, man_b, big_m, small_m, shifted;
  logic             sign_big, sign_small;
  logic [EXP_W-1:0] exp_big;
`ifdef FPU_ROUND_EN
  logic             sticky;
`endif

  always_comb begin
    man_a = MW'({~zero_a, a_q.frac}) << GRS_W;
    man_b = MW'({~zero_b, b_q.frac}) << GRS_W;
    a_big = (a_q.exp >= b_q.exp);
    if (a_big) begin
      diff       = a_q.exp - b_q.exp;
      big_m      = man_a;
      small_m    = man_b;
      sign_big   = a_q.sign;
      sign_small = b_q.sign;
      exp_big    = a_q.exp;
    end else begin
      diff       = b_q.exp - a_q.exp;
      big_m      = man_b;
      small_m    = man_a;
      sign_big   = b_q.sign;
      sign_small = a_q.sign;
      exp_big    = b_q.exp;
    end
    shifted = (32'(diff) >= MW) ? '0 : (small_m >> diff);
`ifdef FPU_ROUND_EN
    // Sticky collects every bit pushed past the round position.
    if (32'(diff) >= MW) sticky = |small_m;
    else                 sticky = |(small_m & ~({MW{1'b1}} << diff));
    shifted[0] = shifted[0] | sticky;
`endif
  end

  // Special operands bypass the arithmetic path.
  logic        spec_nan, spec_hit;
  logic [15:0] spec_val;

  always_comb begin
    spec_nan = nan_a || nan_b || (inf_a && inf_b && (a_q.sign != b_q.sign));
    spec_hit = spec_nan || inf_a || inf_b;
    if (spec_nan)   spec_val = FP16_QNAN;
    else if (inf_a) spec_val = a_q;
    else            spec_val = b_q;
  end

  // Pack datapath: optional round-to-nearest-even, then field extraction.
  logic [FP16_FRAC_W-1:0] frac_p;
  logic [XW-1:0]          exp_p;
`ifdef FPU_ROUND_EN
  logic                   round_up;
  logic [MAN_W:0]         mant_r;
`endif

  always_comb begin
    frac_p = sum_q[HID-1:GRS_W];
    exp_p  = exp_q;
`ifdef FPU_ROUND_EN
    round_up = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[GRS_W]);
    mant_r   = (MAN_W+1)'(sum_q[HID:GRS_W]) + (MAN_W+1)'(round_up);
    if (mant_r[MAN_W]) begin
      frac_p = mant_r[MAN_W-1:1];
      exp_p  = exp_q + XW'(1);
    end else begin
      frac_p = mant_r[MAN_W-2:0];
    end
`endif
  end

  // Mantissa add/subtract result for the ADD state.
  logic [SW-1:0] add_res;
  logic          add_sign;

  always_comb begin
    if (sign_x_q == sign_y_q) begin
      add_res  = SW'(man_x_q) + SW'(man_y_q);
      add_sign = sign_x_q;
    end else if (man_x_q >= man_y_q) begin
      add_res  = SW'(man_x_q) - SW'(man_y_q);
      add_sign = sign_x_q;
    end else begin
      add_res  = SW'(man_y_q) - SW'(man_x_q);
      add_sign = sign_y_q;
    end
    if (add_res == '0) add_sign = 1'b0;
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    special_d   = special_q;
    spec_res_d  = spec_res_q;
    man_x_d     = man_x_q;
    man_y_d     = man_y_q;
    sign_x_d    = sign_x_q;
    sign_y_d    = sign_y_q;
    exp_d       = exp_q;
    sum_d       = sum_q;
    sign_d      = sign_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = fp16_t'(op_a);
          b_d     = fp16_t'(op_b ^ (16'(op_sub) << FP16_SIGN_POS));
          state_d = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        special_d  = spec_hit;
        spec_res_d = spec_val;
        man_x_d    = big_m;
        man_y_d    = shifted;
        sign_x_d   = sign_big;
        sign_y_d   = sign_small;
        exp_d      = XW'(exp_big);
        state_d    = ST_ADD;
      end
      ST_ADD: begin
        if (special_q) begin
          result_d    = spec_res_q;
          overflow_d  = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          sum_d   = add_res;
          sign_d  = add_sign;
          cnt_d   = '0;
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        if (sum_q[SW-1]) begin
          sum_d = sum_q >> 1;
`ifdef FPU_ROUND_EN
          sum_d[0] = sum_q[1] | sum_q[0];
`endif
          exp_d   = exp_q + XW'(1);
          state_d = ST_PACK;
        end else if (!sum_q[HID] && (sum_q != '0) && (exp_q > XW'(1)) &&
                     (32'(cnt_q) < NORM_MAX)) begin
          sum_d = sum_q << 1;
          exp_d = exp_q - XW'(1);
          cnt_d = cnt_q + CW'(1);
        end else begin
          // Hidden bit never reached: underflow or exact zero.
          if (!sum_q[HID]) begin
            sum_d = '0;
            exp_d = '0;
          end
          state_d = ST_PACK;
        end
      end
      ST_PACK: begin
        if (exp_p >= XW'(FP16_EXP_MAX)) begin
          result_d   = {sign_q, FP16_EXP_MAX, {FP16_FRAC_W{1'b0}}};
          overflow_d = 1'b1;
        end else begin
          result_d   = {sign_q, exp_p[EXP_W-1:0], frac_p};
          overflow_d = 1'b0;
        end
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      special_q   <= 1'b0;
      spec_res_q  <= '0;
      man_x_q     <= '0;
      man_y_q     <= '0;
      sign_x_q    <= 1'b0;
      sign_y_q    <= 1'b0;
      exp_q       <= '0;
      sum_q       <= '0;
      sign_q      <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      special_q   <= special_d;
      spec_res_q  <= spec_res_d;
      man_x_q     <= man_x_d;
      man_y_q     <= man_y_d;
      sign_x_q    <= sign_x_d;
      sign_y_q    <= sign_y_d;
      exp_q       <= exp_d;
      sum_q       <= sum_d;
      sign_q      <= sign_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Directed self-checking bench for fpu_addsub_seq.
module tb_fpu_addsub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fpu_addsub_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Wait for in_ready, present one operand pair, return just after the accept edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic sub, input string tag);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    tick();
    in_valid = 1'b0;
  endtask

  // Count cycles from the accept edge until out_valid rises.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic [15:0] er, input logic eo, input int elat, input string tag);
    int lat;
    start_op(a, b, sub, tag);
    wait_valid(lat);
    chk({tag, "_latency"},  32'(lat),      32'(elat));
    chk({tag, "_result"},   32'(result),   32'(er));
    chk({tag, "_overflow"}, 32'(overflow), 32'(eo));
    chk({tag, "_busy_ir"},  32'({busy, in_ready}), 32'b10);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_consumed"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sub    = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result",    32'(result),    32'h0000);
    chk("rst_overflow",  32'(overflow),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    run_op(16'h3C00, 16'h4000, 1'b0, 16'h4200, 1'b0, 4,  "one_plus_two");
    run_op(16'h3E00, 16'h3DFF, 1'b1, 16'h1400, 1'b0, 14, "ten_shifts");
    run_op(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0, 4,  "exact_zero");
    run_op(16'h4000, 16'h3C00, 1'b1, 16'h3C00, 1'b0, 5,  "two_minus_one");
    run_op(16'h3C00, 16'h4000, 1'b1, 16'hBC00, 1'b0, 5,  "one_minus_two");
    run_op(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, 4,  "max_overflow");
    run_op(16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 1'b0, 2,  "inf_minus_inf");
    run_op(16'h7C01, 16'h3C00, 1'b0, 16'h7E00, 1'b0, 2,  "nan_in");
    run_op(16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 1'b0, 2,  "inf_prop");
`ifdef FPU_ROUND_EN
    run_op(16'h6800, 16'h3E00, 1'b0, 16'h6801, 1'b0, 4,  "far_align");
`else
    run_op(16'h6800, 16'h3E00, 1'b0, 16'h6800, 1'b0, 4,  "far_align");
`endif
    run_op(16'h6800, 16'h3C00, 1'b0, 16'h6800, 1'b0, 4,  "tie_even");

    // Back-pressure: result held while out_ready is low.
    start_op(16'h3C00, 16'h4000, 1'b0, "stall");
    wait_valid(lat);
    chk("stall_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      chk("stall_result",    32'(result),    32'h4200);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready",  32'(in_ready),  32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stall_release", 32'({out_valid, in_ready}), 32'b01);

    // Reset in the middle of a long normalize aborts without output.
    start_op(16'h3E00, 16'h3DFF, 1'b1, "abort");
    for (int i = 0; i < 5; i++) tick();
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy",      32'(busy),      32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result",    32'(result),    32'h0000);
    for (int i = 0; i < 20; i++) begin
      chk("abort_no_output", 32'(out_valid), 32'd0);
      if (busy === 1'b1) break;
      if (i == 3) break;
      tick();
    end
    run_op(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 4, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
